// File: rtl/router_pkt_rx.sv
// rtl/router_pkt_rx.sv - router-side packet receiver: parse header, route bytes to destination FIFOs, check parity/length
//
// Ports:
//   clock      in   1         single clock, all state on posedge
//   reset      in   1         asynchronous, active-high; clears all state
//   data_in    in   DATA_W    header / payload / parity byte from source
//   pkt_valid  in   1         high for header+payload bytes, low on the parity byte
//   busy       out  1         byte on data_in is not accepted this cycle (source holds it)
//   error      out  1         one-cycle pulse: parity or length mismatch on finished packet
//   fifo_full  in   NUM_DEST  full flags of destination FIFOs
//   wr_en      out  NUM_DEST  one-hot write strobe to destination FIFO
//   dout       out  DATA_W    write data to destination FIFOs (same as data_in)
//   pkt_done   out  1         one-cycle pulse when any packet (routed or dropped) completes
module router_pkt_rx #(
   parameter int DATA_W   = 8,
   parameter int NUM_DEST = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                pkt_valid,
   output logic                busy,
   output logic                error,
   input  logic [NUM_DEST-1:0] fifo_full,
   output logic [NUM_DEST-1:0] wr_en,
   output logic [DATA_W-1:0]   dout,
   output logic                pkt_done
);

   localparam int LEN_W = DATA_W - 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2,
      DROP  = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [1:0]        dest, dest_nxt;
   logic [LEN_W-1:0]  len, len_nxt;
   logic [LEN_W-1:0]  cnt, cnt_nxt;
   logic [DATA_W-1:0] par, par_nxt;
   logic              ovf, ovf_nxt;
   logic              err, err_nxt;

   logic [1:0]        addr;
   logic              addr_ok;
   logic              hdr_full;
   logic              dest_full;
   logic              write;
   logic [1:0]        route;

   assign addr    = data_in[1:0];
   assign addr_ok = int'(addr) < NUM_DEST;
   assign dout    = data_in;

   // Full flag of the FIFO addressed by the incoming header and by the latched destination.
   // Addresses beyond NUM_DEST never match, so no out-of-range index is formed.
   always_comb begin
      hdr_full  = 1'b0;
      dest_full = 1'b0;
      for (int d = 0; d < NUM_DEST; d++) begin
         if (addr == d[1:0]) hdr_full  = fifo_full[d];
         if (dest == d[1:0]) dest_full = fifo_full[d];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         dest  <= '0;
         len   <= '0;
         cnt   <= '0;
         par   <= '0;
         ovf   <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         dest  <= dest_nxt;
         len   <= len_nxt;
         cnt   <= cnt_nxt;
         par   <= par_nxt;
         ovf   <= ovf_nxt;
         err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      dest_nxt  = dest;
      len_nxt   = len;
      cnt_nxt   = cnt;
      par_nxt   = par;
      ovf_nxt   = ovf;
      err_nxt   = err;
      busy      = 1'b0;
      write     = 1'b0;
      route     = dest;
      unique case (state)
         IDLE: begin
            route = addr;
            if (pkt_valid) begin
               if (!addr_ok) begin
                  state_nxt = DROP;
               end else begin
                  busy = hdr_full;
                  if (!hdr_full) begin
                     write     = 1'b1;
                     dest_nxt  = addr;
                     len_nxt   = data_in[DATA_W-1:2];
                     par_nxt   = data_in;
                     cnt_nxt   = '0;
                     ovf_nxt   = 1'b0;
                     state_nxt = LOAD;
                  end
               end
            end
         end
         LOAD: begin
            busy = dest_full;
            if (!dest_full) begin
               write = 1'b1;
               if (pkt_valid) begin
                  par_nxt = par ^ data_in;
                  // Counter sticks at its maximum; any further payload byte is a length error.
                  if (cnt == {LEN_W{1'b1}}) ovf_nxt = 1'b1;
                  else                      cnt_nxt = cnt + 1'b1;
               end else begin
                  err_nxt   = (data_in != par) || (cnt != len) || ovf;
                  state_nxt = CHECK;
               end
            end
         end
         CHECK: begin
            busy      = 1'b1;
            state_nxt = IDLE;
         end
         DROP: begin
            if (!pkt_valid) begin
               err_nxt   = 1'b0;
               state_nxt = CHECK;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wr_en = '0;
      for (int d = 0; d < NUM_DEST; d++) begin
         wr_en[d] = write && (route == d[1:0]);
      end
   end

   assign pkt_done = (state == CHECK);
   assign error    = (state == CHECK) && err;

endmodule

// File: tb/tb_router_pkt_rx.sv
// tb/tb_router_pkt_rx.sv - scoreboard testbench for router_pkt_rx
module tb_router_pkt_rx;

   logic       clock;
   logic       reset;
   logic [7:0] data_in;
   logic       pkt_valid;
   logic       busy;
   logic       error;
   logic [2:0] fifo_full;
   logic [2:0] wr_en;
   logic [7:0] dout;
   logic       pkt_done;

   router_pkt_rx #(.DATA_W(8), .NUM_DEST(3)) dut (
      .clock     (clock),
      .reset     (reset),
      .data_in   (data_in),
      .pkt_valid (pkt_valid),
      .busy      (busy),
      .error     (error),
      .fifo_full (fifo_full),
      .wr_en     (wr_en),
      .dout      (dout),
      .pkt_done  (pkt_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   int exp_wr[$];   // {onehot dest, byte}
   int exp_err[$];  // expected error flag per completed packet

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s: condition not met", name);
   endtask

   // Monitor: pops expected writes and packet completions as the DUT presents them.
   always @(negedge clock) begin
      if (!reset) begin
         if (wr_en != 3'b000) begin
            if (exp_wr.size() == 0) begin
               fail("unexpected_write");
            end else begin
               int e;
               e = exp_wr.pop_front();
               chk("wr_dest", int'(wr_en), e >> 8);
               chk("wr_data", int'(dout), e & 255);
            end
         end
         if (pkt_done) begin
            if (exp_err.size() == 0) begin
               fail("unexpected_pkt_done");
            end else begin
               int e;
               e = exp_err.pop_front();
               chk("pkt_error", int'(error), e);
            end
         end else if (error) begin
            fail("error_without_pkt_done");
         end
      end
   end

   // Present a byte and wait (bounded) for the cycle in which it is accepted.
   task automatic wait_accept();
      int n;
      n = 0;
      forever begin
         @(negedge clock);
         if (!busy) break;
         n++;
         if (n > 50) begin
            fail("accept_timeout");
            break;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic v, input int dest);
      if (dest >= 0) exp_wr.push_back(((1 << dest) << 8) | int'(b));
      data_in   = b;
      pkt_valid = v;
      wait_accept();
   endtask

   // Parity byte: afterwards the DUT sits in its single busy completion cycle.
   task automatic send_parity(input logic [7:0] b, input int dest, input int err);
      exp_err.push_back(err);
      send(b, 1'b0, dest);
      chk("busy_in_check", int'(busy), 1);
      data_in = 8'h00;
   endtask

   initial begin
      reset     = 1'b1;
      data_in   = 8'h00;
      pkt_valid = 1'b0;
      fifo_full = 3'b000;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_pkt_done", int'(pkt_done), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;

      // 1: len5 addr1, good parity
      send(8'h15, 1'b1, 1);
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1);
      send_parity(8'h14, 1, 0);

      // 2: same packet, bad parity
      send(8'h15, 1'b1, 1);
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1);
      send_parity(8'h15, 1, 1);

      // 3: addr3 is dropped, no writes
      send(8'h0B, 1'b1, -1);
      send(8'hAA, 1'b1, -1);
      send(8'hBB, 1'b1, -1);
      send_parity(8'h5C, -1, 0);

      // 4: len2 addr0 with fifo_full[0] stalling the second payload byte for 3 cycles
      send(8'h08, 1'b1, 0);
      send(8'hA5, 1'b1, 0);
      fifo_full = 3'b001;
      exp_wr.push_back((1 << 8) | 8'h5A);
      data_in   = 8'h5A;
      pkt_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("stall_busy", int'(busy), 1);
         chk("stall_wr_en", int'(wr_en), 0);
         @(posedge clock); #1;
      end
      fifo_full = 3'b000;
      wait_accept();
      send_parity(8'hF7, 0, 0);

      // 5: len3 addr2 but only two payload bytes, parity correct
      send(8'h0E, 1'b1, 2);
      send(8'h11, 1'b1, 2);
      send(8'h22, 1'b1, 2);
      send_parity(8'h3D, 2, 1);

      // len0 addr2: parity equals header
      send(8'h02, 1'b1, 2);
      send_parity(8'h02, 2, 0);

      // 6: reset during payload byte 3 of packet 1
      send(8'h15, 1'b1, 1);
      send(8'h01, 1'b1, 1);
      send(8'h02, 1'b1, 1);
      data_in   = 8'h03;
      pkt_valid = 1'b1;
      reset     = 1'b1;
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_wr_en", int'(wr_en), 0);
      chk("mid_rst_error", int'(error), 0);
      chk("mid_rst_pkt_done", int'(pkt_done), 0);
      @(posedge clock); #1;
      pkt_valid = 1'b0;
      data_in   = 8'h00;
      reset     = 1'b0;
      @(posedge clock); #1;
      send(8'h04, 1'b1, 0);
      send(8'h77, 1'b1, 0);
      send_parity(8'h73, 0, 0);

      pkt_valid = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      chk("wr_queue_empty", exp_wr.size(), 0);
      chk("err_queue_empty", exp_err.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
